// File: rtl/twin_reg_pkg.sv
// Shared types, frame constants and helper functions for the twin-register
// serializer.
package twin_reg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DATA_BITS  = 16;
  localparam int FRAME_BITS = 19;

  // Parity bit that makes the total number of ones across data+parity even.
  function automatic logic even_parity16(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

  // Arranges both bytes so that bit 15 of the result is the first bit on the
  // wire. Byte order is always b1 then b2; msb_first picks the bit order.
  function automatic logic [DATA_BITS-1:0] frame_order(
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic       msb_first
  );
    logic [DATA_BITS-1:0] seq;
    seq = {b1, b2};
    if (!msb_first) begin
      for (int i = 0; i < 8; i++) begin
        seq[15-i] = b1[i];
        seq[7-i]  = b2[i];
      end
    end
    return seq;
  endfunction

endpackage

// File: rtl/twin_reg_serializer_bit_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// tick_next tells the parent whether the coming cycle will be a tick cycle,
// so the parent can register outputs that line up with the tick.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam logic [7:0] TERM = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_next;

  // Next count: restart wins, otherwise wrap on the terminal count.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a value on every path
    // (here via the default first) so no latch is inferred.
    cnt_next = cnt + 8'd1;
    if (restart || cnt == TERM) begin
      cnt_next = '0;
    end
  end

  // Counter register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign tick      = (cnt == TERM);
  assign tick_next = (cnt_next == TERM);

endmodule

// File: rtl/twin_reg_serializer.sv
// Reads the twin 8-bit register pair (d1, d2) through a valid/ready handshake
// and sends it as one UART-like frame: start, 16 data bits, even parity, stop.
module twin_reg_serializer
  import twin_reg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_t state;
  state_t state_next;

  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_next;
  logic [3:0]           bit_idx;
  logic [3:0]           bit_idx_next;
  logic                 parity;
  logic                 parity_next;

  logic tx_next;
  logic busy_next;
  logic done_next;

  logic capture;
  logic tick;
  logic tick_next;

  assign load_ready = rst && (state == IDLE);
  assign capture    = load_valid && load_ready;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart  (capture),
    .tick     (tick),
    .tick_next(tick_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each non-idle state lasts one bit period; DATA repeats
  // for all 16 bits before moving on.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (capture) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && bit_idx == 4'd15) state_next = PARITY;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values: latch the bytes and parity at capture, shift one
  // bit out at the end of each data bit period.
  always_comb begin
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    parity_next  = parity;
    if (capture) begin
      shreg_next   = frame_order(d1, d2, MSB_FIRST);
      bit_idx_next = '0;
      parity_next  = even_parity16({d1, d2});
    end else if (state == DATA && tick) begin
      shreg_next   = {shreg[DATA_BITS-2:0], 1'b0};
      bit_idx_next = bit_idx + 4'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is a handful of flops, not a memory array, so
    // it is cleared on reset like any other state.
    if (!rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      parity  <= 1'b0;
    end else begin
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      parity  <= parity_next;
    end
  end

  // Output logic: derived from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    tx_next = 1'b1;
    unique case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[DATA_BITS-1];
      PARITY:  tx_next = parity_next;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
    done_next = (state_next == STOP) && tick_next;
  end

  // Output registers; reset forces the line idle and aborts any frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx   <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      tx   <= tx_next;
      busy <= busy_next;
      done <= done_next;
    end
  end

endmodule

// File: tb/tb_twin_reg_serializer.sv
// Bench for twin_reg_serializer: one instance with 4 clocks per bit, MSB
// first, and one with 1 clock per bit, LSB first. Expected frames come from a
// bit-list model built from d1/d2.
module tb_twin_reg_serializer;

  localparam int FRAME = 19;

  logic       clk = 1'b0;
  logic       rst;
  logic       lv;
  logic       sel;
  logic [7:0] d1;
  logic [7:0] d2;

  logic lv0, lv1;
  logic lr0, tx0, busy0, done0;
  logic lr1, tx1, busy1, done1;
  logic cur_lr, cur_tx, cur_busy, cur_done;

  int   checks = 0;
  int   errors = 0;
  int   cpb;
  bit   msb;
  logic exp_bits [FRAME];

  always #5 clk = ~clk;

  assign lv0 = lv & ~sel;
  assign lv1 = lv & sel;

  assign cur_lr   = sel ? lr1   : lr0;
  assign cur_tx   = sel ? tx1   : tx0;
  assign cur_busy = sel ? busy1 : busy0;
  assign cur_done = sel ? done1 : done0;

  twin_reg_serializer #(.CLKS_PER_BIT(4), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(lr0),
    .d1(d1), .d2(d2), .tx(tx0), .busy(busy0), .done(done0)
  );

  twin_reg_serializer #(.CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(lr1),
    .d1(d1), .d2(d2), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference frame: start, byte d1 then byte d2 in the chosen bit order,
  // a parity bit that is 1 when the data has an odd number of ones, stop.
  task automatic build_model(input logic [7:0] a, input logic [7:0] b);
    int   ones;
    logic [7:0] byte_v;
    int   pos;
    ones = $countones({a, b});
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      byte_v = (i < 8) ? a : b;
      pos    = i % 8;
      exp_bits[1 + i] = msb ? byte_v[7 - pos] : byte_v[pos];
    end
    exp_bits[17] = (ones % 2 == 1);
    exp_bits[18] = 1'b1;
  endtask

  task automatic check_idle(input string tag, input logic exp_lr);
    check({tag, " tx"},   cur_tx,   1'b1);
    check({tag, " busy"}, cur_busy, 1'b0);
    check({tag, " done"}, cur_done, 1'b0);
    check({tag, " lr"},   cur_lr,   exp_lr);
  endtask

  // Called at a negedge with the selected DUT idle. Captures (a, b) on the
  // next edge and checks every cycle of the frame. hold keeps load_valid high;
  // inj_lo..inj_hi raises load_valid mid-frame; abort_at>0 resets at that cycle.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit hold,
                      input int inj_lo, input int inj_hi, input int abort_at);
    int n;
    n = FRAME * cpb;
    build_model(a, b);
    check_idle($sformatf("s%0d pre", sel), 1'b1);
    lv = 1'b1;
    d1 = a;
    d2 = b;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      check($sformatf("s%0d %h%h tx c%0d", sel, a, b, j), cur_tx, exp_bits[(j - 1) / cpb]);
      check($sformatf("s%0d busy c%0d", sel, j), cur_busy, 1'b1);
      check($sformatf("s%0d done c%0d", sel, j), cur_done, j == n);
      check($sformatf("s%0d lr c%0d", sel, j), cur_lr, 1'b0);
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      if (j >= inj_lo && j <= inj_hi) d1 = 8'h00;
      lv = hold || (j >= inj_lo && j <= inj_hi);
      if (j == abort_at) begin
        rst = 1'b0;
        lv  = 1'b0;
        @(negedge clk);
        check_idle($sformatf("s%0d abort", sel), 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 2 * n; k++) begin
          @(negedge clk);
          check_idle($sformatf("s%0d post-abort %0d", sel, k), 1'b1);
        end
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    lv  = 1'b0;
    sel = 1'b0;
    d1  = 8'h00;
    d2  = 8'h00;
    cpb = 4;
    msb = 1'b1;

    // Reset then idle.
    repeat (3) begin
      @(negedge clk);
      check_idle("in reset", 1'b0);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle %0d", i), 1'b1);
    end

    // Directed frames: basic, odd parity, even parity.
    send(8'hAA, 8'hF0, 1'b0, 0, -1, 0);
    send(8'hCC, 8'hE3, 1'b0, 0, -1, 0);
    send(8'hBB, 8'hFC, 1'b0, 0, -1, 0);

    // Load attempt while busy is ignored.
    send(8'hA5, 8'h5A, 1'b0, 10, 40, 0);

    // Back-to-back with load_valid held high: one idle cycle between frames.
    send(8'hA3, 8'hE4, 1'b1, 0, -1, 0);
    send(8'h11, 8'h22, 1'b0, 0, -1, 0);

    // Reset mid-frame, then a complete frame.
    send(8'h3C, 8'hC3, 1'b0, 0, -1, 30);
    send(8'h5A, 8'h96, 1'b0, 0, -1, 0);

    // Random frames.
    repeat (4) send(8'($urandom), 8'($urandom), 1'b0, 0, -1, 0);
    repeat (3) @(negedge clk);
    check_idle("s0 end", 1'b1);

    // One clock per bit, LSB first.
    sel = 1'b1;
    cpb = 1;
    msb = 1'b0;
    @(negedge clk);
    send(8'hAA, 8'hF0, 1'b0, 0, -1, 0);
    send(8'h80, 8'h01, 1'b1, 0, -1, 0);
    send(8'hCC, 8'hE3, 1'b0, 0, -1, 0);
    send(8'h3C, 8'hC3, 1'b0, 3, 8, 0);
    send(8'hFF, 8'h00, 1'b0, 0, -1, 9);
    repeat (4) send(8'($urandom), 8'($urandom), 1'b0, 0, -1, 0);
    repeat (3) @(negedge clk);
    check_idle("s1 end", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/twin_reg_serializer.md
Name: twin_reg_serializer

Overview:
Reads the contents of a twin 8-bit register pair (d1, d2) and transmits both bytes as one serial frame on a single wire.
- It is the read/transmit end of the twin-register storage: the twin register pair is written, and this block reads it out serially.
- Parallel capture uses a valid/ready handshake.
- Output framing is UART-like: start bit, 16 data bits, even-parity bit, stop bit.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 1..255.
MSB_FIRST, 1, 1 = d1[7] first, through d2[0] last; 0 = d1[0] first, through d2[7] last (byte order is always d1 then d2).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low (rst=0 resets on next rising clk)
load_valid  in  1  d1/d2 presented for capture
load_ready  out  1  block can accept a load this cycle
d1  in  8  first register byte
d2  in  8  second register byte
tx  out  1  serial output, idle high
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse in the final cycle of the stop bit

Behaviour:
- Reset (rst=0 at an edge) applies from that edge onward: state=IDLE, tx=1, busy=0, done=0, shift register and counters cleared.
- load_ready=0 whenever rst=0; otherwise load_ready=(state==IDLE). load_ready is combinational from state and rst.
- Handshake: capture occurs at an edge where load_valid=1 and load_ready=1. At that edge:
  - {d1,d2} is latched.
  - Parity = XOR of all 16 bits (even parity; the parity bit makes the total count of ones even).
  - state goes to START.
- load_valid while busy is ignored; data is not queued.
- States and durations (each state lasts exactly CLKS_PER_BIT cycles, timed by a bit-tick counter):
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: 16 bits, bit index 0..15, order per MSB_FIRST.
  - PARITY: tx=parity.
  - STOP: tx=1.
  - Then back to IDLE.
- Latency: with the handshake at edge k, tx=0 is visible after edge k and stays low for CLKS_PER_BIT cycles.
- Frame length: 19*CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle inclusive.
- busy=1 from the capture edge through the last STOP cycle.
- done=1 only in the last STOP cycle.
- Back-to-back: the state returns to IDLE after the last STOP cycle. If load_valid is held, the next capture occurs on the following edge. Minimum inter-frame gap is 1 idle cycle at tx=1.
- tx, busy and done are registered outputs: no combinational path from inputs to them.
- Reset mid-frame: the frame is aborted and tx returns to 1 after the reset edge. There is no done pulse, and captured data is discarded.
- d1/d2 changing after capture has no effect on the frame in flight.
- CLKS_PER_BIT=1: one bit per cycle; the same rules apply.

Decomposition:
- Shared package twin_reg_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - localparams DATA_BITS=16 and FRAME_BITS=19;
  - function even_parity16.
- One natural sub-module, bit_tick_gen:
  - counter from 0 to CLKS_PER_BIT-1 with a tick output on the terminal count;
  - synchronously cleared by rst=0 or by a restart strobe asserted at capture.

Test Plan:
1. Reset then idle: hold rst=0 for 3 cycles, then release with load_valid=0 for 10 cycles -> tx=1, busy=0, done=0, load_ready=0 during reset and 1 after release.
2. Basic frame, CLKS_PER_BIT=4, MSB_FIRST=1: load d1=8'hAA, d2=8'hF0.
   - Sampled bits: 0, 10101010, 11110000, parity 0, 1.
   - busy high for 76 cycles; done pulses once, in cycle 76.
3. Odd parity data: d1=8'hCC, d2=8'hE3 -> 9 ones, so the parity bit is 1. Then d1=8'hBB, d2=8'hFC -> 12 ones, so the parity bit is 0.
4. Load while busy: assert load_valid with d1=8'h00 mid-frame -> ignored, frame bits unchanged, load_ready=0 throughout.
5. Back-to-back with load_valid held high:
   - frame 1 d1=8'hA3, d2=8'hE4; frame 2 d1=8'h11, d2=8'h22;
   - exactly one idle cycle with tx=1 between the frames; both frames decode correctly.
6. Reset mid-frame: set rst=0 at cycle 30 of a frame -> tx=1 and busy=0 after that edge, no done pulse; a new load after release sends a complete, correct frame.
